// File: rtl/bcd_to_bin.sv
// bcd_to_bin: serial 4-digit BCD to 14-bit binary converter (reverse double-dabble).
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/bcd_in[15:0] input handshake;
//        out_valid/out_ready/bin_out[13:0]/err result handshake.
// Option: define BCD_DIGIT_CHECK_EN to flag captured nibbles > 9 (err=1, bin_out=0).
module bcd_to_bin (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] bcd_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] bin_out,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_digits;
    logic [13:0] r_result;
    logic [3:0]  r_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [13:0] r_bin_out;
    logic        r_err;

    logic [29:0] w_shift;
    logic [15:0] w_dig_adj;
    logic [13:0] w_res_sh;
    logic [3:0]  w_nib;

    // One step: shift {digits,result} right, then pull each digit
    // nibble that reached 8 or more back down by 3.
    always_comb begin
        w_shift   = {r_digits, r_result} >> 1;
        w_res_sh  = w_shift[13:0];
        w_dig_adj = '0;
        w_nib     = '0;
        for (int k = 0; k < 4; k++) begin
            w_nib = w_shift[14 + 4*k +: 4];
            if (w_nib >= 4'd8)
                w_dig_adj[4*k +: 4] = w_nib - 4'd3;
            else
                w_dig_adj[4*k +: 4] = w_nib;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic w_bad;
    always_comb begin
        w_bad = 1'b0;
        for (int k = 0; k < 4; k++)
            if (bcd_in[4*k +: 4] > 4'd9)
                w_bad = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_digits    <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_bin_out   <= '0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_digits   <= bcd_in;
                        r_result   <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
                        if (w_bad) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_bin_out   <= '0;
                            r_err       <= 1'b1;
                        end else begin
                            r_state <= S_CONV;
                        end
`else
                        r_state <= S_CONV;
`endif
                    end
                end
                S_CONV: begin
                    r_digits <= w_dig_adj;
                    r_result <= w_res_sh;
                    r_cnt    <= r_cnt + 4'd1;
                    // Step 14 lands the finished value straight in the output.
                    if (r_cnt == 4'd13) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_bin_out   <= w_res_sh;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_bin_out   <= '0;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_bin_out   <= '0;
                    r_err       <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign bin_out   = r_bin_out;
    assign err       = r_err;

endmodule
